// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and access helpers for the data-memory responder
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Natural alignment only depends on the low three address bits.
   function automatic logic align_ok(input logic [2:0] addr_lo, input size_e size);
      case (size)
         SZ_B:    align_ok = 1'b1;
         SZ_H:    align_ok = (addr_lo[0] == 1'b0);
         SZ_W:    align_ok = (addr_lo[1:0] == 2'b00);
         default: align_ok = (addr_lo == 3'b000);
      endcase
   endfunction

   // Byte-enable pattern of an access before it is shifted to its lane.
   function automatic logic [7:0] size_mask(input size_e size);
      case (size)
         SZ_B:    size_mask = 8'h01;
         SZ_H:    size_mask = 8'h03;
         SZ_W:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

   // Pull the addressed field out of a RAM word and sign/zero extend it.
   function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] lane,
                                               input size_e size, input logic is_unsigned);
      logic [63:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         SZ_B:    load_extend = is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
         SZ_H:    load_extend = is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         SZ_W:    load_extend = is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         default: load_extend = sh;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - 64-bit RAM with byte enables, synchronous write and combinational read
module dmem_array #(
   parameter int DEPTH_WORDS = 512,
   parameter int AW          = 9
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    be_i,
   input  logic [63:0]   wdata_i,
   output logic [63:0]   rdata_o
);

   logic [63:0] mem_q [DEPTH_WORDS];

   // Byte-granular write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (we_i && be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV64 data-memory responder FSM; DMEM_STATS_EN adds response counters
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 512,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0] stat_loads,
   output logic [31:0] stat_stores,
   output logic [31:0] stat_errs
`endif
);

   localparam int         AW     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ready_q;
   logic        lat_write_q, lat_write_d;
   size_e       lat_size_q, lat_size_d;
   logic        lat_uns_q, lat_uns_d;
   logic [63:0] lat_addr_q, lat_addr_d;
   logic [63:0] lat_wdata_q, lat_wdata_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        cur_write, cur_uns;
   size_e       cur_size;
   logic [63:0] cur_addr, cur_wdata;
   logic [2:0]  lane;
   logic        in_range, acc_err, accept, commit, ram_we;
   logic [7:0]  ram_be;
   logic [63:0] ram_wdata, ram_rdata;

   // With LATENCY=1 the access happens on the accept edge, so IDLE uses the live request.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_write = req_write;
         cur_size  = size_e'(req_size);
         cur_uns   = req_unsigned;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
      end else begin
         cur_write = lat_write_q;
         cur_size  = lat_size_q;
         cur_uns   = lat_uns_q;
         cur_addr  = lat_addr_q;
         cur_wdata = lat_wdata_q;
      end
   end

   assign lane      = cur_addr[2:0];
   assign in_range  = (cur_addr[63:3+AW] == '0);
   assign acc_err   = !align_ok(cur_addr[2:0], cur_size) || !in_range;
   assign req_ready = ready_q && (state_q == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign ram_be    = size_mask(cur_size) << lane;
   assign ram_wdata = cur_wdata << {lane, 3'b000};
   assign ram_we    = commit && cur_write && !acc_err;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (cur_addr[3 +: AW]),
      .be_i    (ram_be),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // Next-state logic; the RAM access and response capture happen only on entry to RESP.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lat_write_d = lat_write_q;
      lat_size_d  = lat_size_q;
      lat_uns_d   = lat_uns_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      commit      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               lat_write_d = req_write;
               lat_size_d  = size_e'(req_size);
               lat_uns_d   = req_unsigned;
               lat_addr_d  = req_addr;
               lat_wdata_d = req_wdata;
               if (LATENCY == 1) begin
                  commit  = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = LAT_M1;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               cnt_d   = 4'd0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (commit) begin
         err_d   = acc_err;
         rdata_d = (acc_err || cur_write) ? 64'd0 : load_extend(ram_rdata, lane, cur_size, cur_uns);
      end
   end

   // State, request latches and the held response; reset drops any pending transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         ready_q     <= 1'b0;
         lat_write_q <= 1'b0;
         lat_size_q  <= SZ_B;
         lat_uns_q   <= 1'b0;
         lat_addr_q  <= 64'd0;
         lat_wdata_q <= 64'd0;
         rdata_q     <= 64'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= 1'b1;
         lat_write_q <= lat_write_d;
         lat_size_q  <= lat_size_d;
         lat_uns_q   <= lat_uns_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

`ifdef DMEM_STATS_EN
   logic [31:0] loads_q, stores_q, errs_q;
   logic        rsp_hs;

   assign rsp_hs = rsp_valid && rsp_ready;

   // Saturating per-kind counters; an errored access only counts as an error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         loads_q  <= 32'd0;
         stores_q <= 32'd0;
         errs_q   <= 32'd0;
      end else if (rsp_hs) begin
         if (err_q) begin
            if (errs_q != 32'hFFFF_FFFF) errs_q <= errs_q + 32'd1;
         end else if (lat_write_q) begin
            if (stores_q != 32'hFFFF_FFFF) stores_q <= stores_q + 32'd1;
         end else begin
            if (loads_q != 32'hFFFF_FFFF) loads_q <= loads_q + 32'd1;
         end
      end
   end

   assign stat_loads  = loads_q;
   assign stat_stores = stores_q;
   assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (LATENCY 2 and 4)
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic [1:0]  req_size [2];
   logic        req_unsigned [2];
   logic [63:0] req_addr [2];
   logic [63:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [63:0] rsp_rdata [2];
   logic        rsp_err [2];
`ifdef DMEM_STATS_EN
   logic [31:0] stat_loads [2];
   logic [31:0] stat_stores [2];
   logic [31:0] stat_errs [2];
`endif

   int tests = 0;
   int fails = 0;

   dmem_responder #(.DEPTH_WORDS(512), .LATENCY(2)) u_dut_a (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[0]),
      .req_ready    (req_ready[0]),
      .req_write    (req_write[0]),
      .req_size     (req_size[0]),
      .req_unsigned (req_unsigned[0]),
      .req_addr     (req_addr[0]),
      .req_wdata    (req_wdata[0]),
      .rsp_valid    (rsp_valid[0]),
      .rsp_ready    (rsp_ready[0]),
      .rsp_rdata    (rsp_rdata[0]),
      .rsp_err      (rsp_err[0])
`ifdef DMEM_STATS_EN
      ,
      .stat_loads   (stat_loads[0]),
      .stat_stores  (stat_stores[0]),
      .stat_errs    (stat_errs[0])
`endif
   );

   dmem_responder #(.DEPTH_WORDS(512), .LATENCY(4)) u_dut_b (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[1]),
      .req_ready    (req_ready[1]),
      .req_write    (req_write[1]),
      .req_size     (req_size[1]),
      .req_unsigned (req_unsigned[1]),
      .req_addr     (req_addr[1]),
      .req_wdata    (req_wdata[1]),
      .rsp_valid    (rsp_valid[1]),
      .rsp_ready    (rsp_ready[1]),
      .rsp_rdata    (rsp_rdata[1]),
      .rsp_err      (rsp_err[1])
`ifdef DMEM_STATS_EN
      ,
      .stat_loads   (stat_loads[1]),
      .stat_stores  (stat_stores[1]),
      .stat_errs    (stat_errs[1])
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs(input int d);
      req_valid[d]    = 1'b0;
      req_write[d]    = 1'b0;
      req_size[d]     = 2'd0;
      req_unsigned[d] = 1'b0;
      req_addr[d]     = 64'd0;
      req_wdata[d]    = 64'd0;
      rsp_ready[d]    = 1'b0;
   endtask

   // Present a request at a negedge, wait (bounded) for ready, return at the negedge after accept.
   task automatic send(input int d, input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] wd, input string tag);
      int n;
      n = 0;
      req_valid[d]    = 1'b1;
      req_write[d]    = w;
      req_size[d]     = sz;
      req_unsigned[d] = u;
      req_addr[d]     = a;
      req_wdata[d]    = wd;
      while (req_ready[d] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " accept"}, 64'(req_ready[d]), 64'd1);
      @(negedge clk);
      req_valid[d] = 1'b0;
   endtask

   task automatic wait_rsp(input int d, output int lat);
      lat = 1;
      while (rsp_valid[d] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic take(input int d);
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
   endtask

   task automatic xact(input int d, input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] exp_rd,
                       input logic exp_err, input int exp_lat, input string tag);
      int lat;
      send(d, w, sz, u, a, wd, tag);
      wait_rsp(d, lat);
      chk({tag, " lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, " rdata"}, rsp_rdata[d], exp_rd);
      chk({tag, " err"}, 64'(rsp_err[d]), 64'(exp_err));
      take(d);
   endtask

   initial begin
      int lat;
      rst = 1'b0;
      idle_inputs(0);
      idle_inputs(1);
      repeat (2) @(negedge clk);
      chk("rst req_ready", 64'(req_ready[0]), 64'd0);
      chk("rst rsp_valid", 64'(rsp_valid[0]), 64'd0);
      chk("rst rsp_rdata", rsp_rdata[0], 64'd0);
      chk("rst rsp_err", 64'(rsp_err[0]), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready after rst", 64'(req_ready[0]), 64'd1);

      // sized stores and loads
      xact(0, 1'b1, 2'd3, 1'b0, 64'h10, 64'h8877665544332211, 64'd0, 1'b0, 2, "SD 10");
      xact(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 64'h8877665544332211, 1'b0, 2, "LD 10");
      xact(0, 1'b0, 2'd0, 1'b0, 64'h17, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2, "LB 17");
      xact(0, 1'b0, 2'd0, 1'b1, 64'h17, 64'd0, 64'h0000000000000088, 1'b0, 2, "LBU 17");
      xact(0, 1'b0, 2'd1, 1'b0, 64'h12, 64'd0, 64'h0000000000004433, 1'b0, 2, "LH 12");
      xact(0, 1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 64'hFFFFFFFF88776655, 1'b0, 2, "LW 14");
      xact(0, 1'b0, 2'd2, 1'b1, 64'h14, 64'd0, 64'h0000000088776655, 1'b0, 2, "LWU 14");
      xact(0, 1'b1, 2'd0, 1'b0, 64'h11, 64'hFFFFFFFFFFFFFFAB, 64'd0, 1'b0, 2, "SB 11");
      xact(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 64'h887766554433AB11, 1'b0, 2, "LD 10 after SB");

      // misaligned and out-of-range accesses
      xact(0, 1'b1, 2'd3, 1'b0, 64'h20, 64'h0123456789ABCDEF, 64'd0, 1'b0, 2, "SD 20");
      xact(0, 1'b0, 2'd2, 1'b0, 64'h12, 64'd0, 64'd0, 1'b1, 2, "LW 12 misaligned");
      xact(0, 1'b1, 2'd1, 1'b0, 64'h21, 64'hFFFF, 64'd0, 1'b1, 2, "SH 21 misaligned");
      xact(0, 1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 64'h0123456789ABCDEF, 1'b0, 2, "LD 20 unchanged");
      xact(0, 1'b0, 2'd3, 1'b0, 64'h1000, 64'd0, 64'd0, 1'b1, 2, "LD 1000 range");
      xact(0, 1'b1, 2'd3, 1'b0, 64'hFF8, 64'hCAFEF00DDEADBEEF, 64'd0, 1'b0, 2, "SD FF8 last");
      xact(0, 1'b0, 2'd3, 1'b0, 64'hFF8, 64'd0, 64'hCAFEF00DDEADBEEF, 1'b0, 2, "LD FF8 last");

      // response backpressure with a new request parked on the request channel
      send(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, "bp LD 10");
      wait_rsp(0, lat);
      chk("bp lat", 64'(lat), 64'd2);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      req_size[0]  = 2'd3;
      req_addr[0]  = 64'h20;
      for (int i = 0; i < 5; i++) begin
         chk("bp rsp_valid held", 64'(rsp_valid[0]), 64'd1);
         chk("bp rdata held", rsp_rdata[0], 64'h887766554433AB11);
         chk("bp req_ready low", 64'(req_ready[0]), 64'd0);
         @(negedge clk);
      end
      chk("bp req_ready at hs", 64'(req_ready[0]), 64'd0);
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      rsp_ready[0] = 1'b0;
      chk("bp ready after hs", 64'(req_ready[0]), 64'd1);
      chk("bp valid after hs", 64'(rsp_valid[0]), 64'd0);
      @(negedge clk);
      req_valid[0] = 1'b0;
      wait_rsp(0, lat);
      chk("bp next lat", 64'(lat), 64'd2);
      chk("bp next rdata", rsp_rdata[0], 64'h0123456789ABCDEF);
      take(0);

      // reset while a store is still waiting (LATENCY=4 instance)
      xact(1, 1'b1, 2'd3, 1'b0, 64'h30, 64'h1111111111111111, 64'd0, 1'b0, 4, "B SD 30 old");
      xact(1, 1'b0, 2'd3, 1'b0, 64'h30, 64'd0, 64'h1111111111111111, 1'b0, 4, "B LD 30");
      send(1, 1'b1, 2'd3, 1'b0, 64'h30, 64'h2222222222222222, "B SD 30 new");
      rst = 1'b0;
      #1;
      chk("B rst req_ready", 64'(req_ready[1]), 64'd0);
      chk("B rst rsp_valid", 64'(rsp_valid[1]), 64'd0);
      chk("B rst rsp_rdata", rsp_rdata[1], 64'd0);
      chk("B rst rsp_err", 64'(rsp_err[1]), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      xact(1, 1'b0, 2'd3, 1'b0, 64'h30, 64'd0, 64'h1111111111111111, 1'b0, 4, "B LD 30 after rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
